// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } muldiv_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             Start_E;
    muldiv_op_e       MulDivOp_E;
    logic [WIDTH-1:0] SrcA_E;
    logic [WIDTH-1:0] SrcB_E;
    logic             Flush_E;
    logic [WIDTH-1:0] MulDivResult_E;
    logic             MulDivDone_E;
    logic             MulDivStall_E;

    modport master (
        output Start_E, MulDivOp_E, SrcA_E, SrcB_E, Flush_E,
        input  MulDivResult_E, MulDivDone_E, MulDivStall_E
    );

    modport slave (
        input  Start_E, MulDivOp_E, SrcA_E, SrcB_E, Flush_E,
        output MulDivResult_E, MulDivDone_E, MulDivStall_E
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used both for operand magnitude and result sign fixup.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);
    assign result = negate ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add / restoring-divide step per cycle,
// stalling the pipeline until a single-cycle DONE presents the result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    muldiv_state_e    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    muldiv_op_e       op_q, op_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             in_sign_a, in_sign_b, is_div_in, div_zero, div_ovf;
    logic [WIDTH-1:0] abs_a, abs_b, fast_res;

    assign in_sign_a = bus.SrcA_E[WIDTH-1] &&
                       (bus.MulDivOp_E inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign in_sign_b = bus.SrcB_E[WIDTH-1] &&
                       (bus.MulDivOp_E inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    assign is_div_in = bus.MulDivOp_E[2];
    assign div_zero  = is_div_in && (bus.SrcB_E == '0);
    assign div_ovf   = (bus.MulDivOp_E inside {OP_DIV, OP_REM}) &&
                       (bus.SrcA_E == WIDTH'(INT_MIN)) && (bus.SrcB_E == '1);

    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = bus.MulDivOp_E[1] ? bus.SrcA_E : WIDTH'(DIV0_QUOT);
        else if (div_ovf)
            fast_res = bus.MulDivOp_E[1] ? '0 : WIDTH'(INT_MIN);
    end

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.value(bus.SrcA_E), .negate(in_sign_a), .result(abs_a));
    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.value(bus.SrcB_E), .negate(in_sign_b), .result(abs_b));

    // One iteration: multiply accumulates into hi and shifts the multiplier out of lo;
    // divide shifts the dividend out of lo into the remainder and shifts quotient bits in.
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign step_hi   = op_q[2] ? (div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0])
                               : mul_sum[WIDTH:1];
    assign step_lo   = op_q[2] ? {lo_q[WIDTH-2:0], div_ok} : {mul_sum[0], lo_q[WIDTH-1:1]};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, final_res;

    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value({step_hi, step_lo}), .negate(sign_a_q ^ sign_b_q), .result(prod_fix));
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quot (
        .value(step_lo), .negate(sign_a_q ^ sign_b_q), .result(quot_fix));
    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .value(step_hi), .negate(sign_a_q), .result(rem_fix));

    always_comb begin
        unique case (op_q)
            OP_MUL:                      final_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             final_res = quot_fix;
            default:                     final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Start_E && !bus.Flush_E) begin
                    op_d     = bus.MulDivOp_E;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    mag_a_d  = abs_a;
                    mag_b_d  = abs_b;
                    cnt_d    = '0;
                    if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = is_div_in ? abs_a : abs_b;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.Flush_E) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign bus.MulDivStall_E  = ((state_q == S_IDLE) && bus.Start_E && !bus.Flush_E) ||
                                (state_q == S_BUSY);
    assign bus.MulDivDone_E   = (state_q == S_DONE);
    assign bus.MulDivResult_E = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random back-to-back RV32M ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] res;
        int          cyc;
        logic [2:0]  op;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic; lat is cycles from issue to Done.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        int              sa;
        int              sbv;
        longint          p;
        longint unsigned pu;
        logic            ovf;
        sa  = a;
        sbv = b;
        lat = 33;
        r   = '0;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = longint'(sa) * longint'(sbv); r = p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sbv); r = p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'h0, b}); r = p[63:32]; end
            3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
            3'd4: if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                  else if (ovf) begin r = 32'h8000_0000; lat = 1; end
                  else r = sa / sbv;
            3'd5: if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                  else r = a / b;
            3'd6: if (b == 0) begin r = a; lat = 1; end
                  else if (ovf) begin r = 32'h0; lat = 1; end
                  else r = sa % sbv;
            default: if (b == 0) begin r = a; lat = 1; end
                     else r = a % b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.MulDivDone_E) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result %h at cycle %0d with no operation pending",
                         bus.MulDivResult_E, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("result_op%0d", mon_e.op), {32'h0, bus.MulDivResult_E}, {32'h0, mon_e.res});
                check($sformatf("done_cycle_op%0d", mon_e.op), 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Called just after a rising edge; holds Start_E like a stalled pipeline and returns
    // just after the edge that ends the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int          lat;
        exp_t        e;
        model(op, a, b, r, lat);
        bus.Start_E    = 1'b1;
        bus.MulDivOp_E = muldiv_op_e'(op);
        bus.SrcA_E     = a;
        bus.SrcB_E     = b;
        e.res = r;
        e.cyc = cyc + lat;
        e.op  = op;
        exp_q.push_back(e);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check("stall_active", {63'h0, bus.MulDivStall_E}, 64'h1);
            if (k == 1) begin
                bus.SrcA_E = $urandom;
                bus.SrcB_E = $urandom;
            end
        end
        @(negedge clk);
        check("stall_done", {63'h0, bus.MulDivStall_E}, 64'h0);
        @(posedge clk);
        #1;
        bus.Start_E = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [2:0]  op;
        logic [31:0] a, b;
        bus.Start_E    = 1'b0;
        bus.Flush_E    = 1'b0;
        bus.MulDivOp_E = OP_MUL;
        bus.SrcA_E     = '0;
        bus.SrcB_E     = '0;
        #12;
        check("reset_result", {32'h0, bus.MulDivResult_E}, 64'h0);
        check("reset_done", {63'h0, bus.MulDivDone_E}, 64'h0);
        check("reset_stall", {63'h0, bus.MulDivStall_E}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'h0000_5555, 32'd0);
        run_op(3'd6, 32'h0000_1234, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush mid-divide: pipeline drops the instruction, unit must return idle silently.
        bus.Start_E    = 1'b1;
        bus.MulDivOp_E = OP_DIVU;
        bus.SrcA_E     = 32'd1000;
        bus.SrcB_E     = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        bus.Flush_E = 1'b1;
        bus.Start_E = 1'b0;
        @(negedge clk);
        check("flush_stall_busy", {63'h0, bus.MulDivStall_E}, 64'h1);
        @(posedge clk);
        #1;
        bus.Flush_E = 1'b0;
        @(negedge clk);
        check("flush_stall_idle", {63'h0, bus.MulDivStall_E}, 64'h0);
        d0 = done_seen;
        bus.Start_E = 1'b1;
        bus.Flush_E = 1'b1;
        @(negedge clk);
        check("flush_beats_start_stall", {63'h0, bus.MulDivStall_E}, 64'h0);
        @(posedge clk);
        #1;
        bus.Start_E = 1'b0;
        bus.Flush_E = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_done", 64'(done_seen), 64'(d0));
        run_op(3'd0, 32'd3, 32'd4);

        // Asynchronous reset in the middle of a multiply.
        bus.Start_E    = 1'b1;
        bus.MulDivOp_E = OP_MUL;
        bus.SrcA_E     = 32'd9;
        bus.SrcB_E     = 32'd9;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.Start_E = 1'b0;
        #1;
        check("midreset_result", {32'h0, bus.MulDivResult_E}, 64'h0);
        check("midreset_done", {63'h0, bus.MulDivDone_E}, 64'h0);
        check("midreset_stall", {63'h0, bus.MulDivStall_E}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(3'd0, 32'd6, 32'd7);
        run_op(3'd0, 32'hFFFF_FFFF, 32'd5);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'($urandom_range(1, 5)) ^ {32{b[31]}};
                default: ;
            endcase
            run_op(op, a, b);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
